// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, branch funct3 and ALU op encodings shared by the decode stage
package decode_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // SUB only exists in register form; SRA is selected by instr[30] in both forms
   function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
      case (f3)
         3'd0:    alu_op_decode = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'd1:    alu_op_decode = ALU_SLL;
         3'd2:    alu_op_decode = ALU_SLT;
         3'd3:    alu_op_decode = ALU_SLTU;
         3'd4:    alu_op_decode = ALU_XOR;
         3'd5:    alu_op_decode = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_op_decode = ALU_OR;
         default: alu_op_decode = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_register_file.sv
// rtl/decode_register_file.sv - 32x32 register file, two async reads, one sync write with write-back bypass
module decode_register_file #(
   parameter bit REG_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] regs [0:31];

   // write port; x0 is never written so it can stay unreset when REG_RESET is 0
   always_ff @(posedge clk) begin
      if (REG_RESET && rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   // read ports: x0 is hard zero, a same-cycle write to the read index is bypassed
   always_comb begin
      rs1_data = regs[rs1];
      if (rs1 == 5'd0)               rs1_data = '0;
      else if (we && wa == rs1)      rs1_data = wd;
      rs2_data = regs[rs2];
      if (rs2 == 5'd0)               rs2_data = '0;
      else if (we && wa == rs2)      rs2_data = wd;
   end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - decode stage: IF/ID register, regfile read, immediates, control, branch resolve, hazard stall
module decode
   import decode_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR_P = NOP_INSTR,
   parameter bit          REG_RESET   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_f,
   input  logic [31:0] pc_f,
   input  logic        flush_m,
   input  logic        reg_write_e,
   input  logic        mem_read_e,
   input  logic [4:0]  rd_e,
   input  logic        reg_write_m,
   input  logic        mem_read_m,
   input  logic [4:0]  rd_m,
   input  logic [31:0] alu_result_m,
   input  logic        reg_write_w,
   input  logic [4:0]  rd_w,
   input  logic [31:0] rd_data_w,
   output logic        stall_f,
   output logic        branch_d,
   output logic [31:0] branch_next_addr_d,
   output logic        valid_d,
   output logic [31:0] pc_d,
   output logic [4:0]  rs1_d,
   output logic [4:0]  rs2_d,
   output logic [4:0]  rd_d,
   output logic [31:0] rs1_data_d,
   output logic [31:0] rs2_data_d,
   output logic [31:0] imm_d,
   output logic [2:0]  funct3_d,
   output logic [3:0]  alu_op_d,
   output logic        alu_src_d,
   output logic        mem_read_d,
   output logic        mem_write_d,
   output logic        reg_write_d
);

   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;

   // IF/ID register: reset > memory redirect > own redirect > hazard hold > load
   always_ff @(posedge clk) begin
      if (rst || flush_m || branch_d) begin
         ifid_instr <= NOP_INSTR_P;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else if (!stall_f) begin
         ifid_instr <= instruction_f;
         ifid_pc    <= pc_f;
         ifid_valid <= 1'b1;
      end
   end

   logic [6:0] opcode;
   logic [2:0] funct3;
   assign opcode = ifid_instr[6:0];
   assign funct3 = ifid_instr[14:12];
   assign rd_d   = ifid_instr[11:7];
   assign rs1_d  = ifid_instr[19:15];
   assign rs2_d  = ifid_instr[24:20];
   assign pc_d   = ifid_pc;

   decode_register_file #(.REG_RESET(REG_RESET)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1      (rs1_d),
      .rs2      (rs2_d),
      .rs1_data (rs1_data_d),
      .rs2_data (rs2_data_d),
      .we       (reg_write_w),
      .wa       (rd_w),
      .wd       (rd_data_w)
   );

   logic        legal, uses_rs1, uses_rs2, is_branch, is_jal, is_jalr;
   logic        ctl_alu_src, ctl_mem_read, ctl_mem_write, ctl_reg_write;
   logic [31:0] imm;
   alu_op_e     alu_op;

   // opcode decode: operand usage, immediate format and raw control
   always_comb begin
      legal         = 1'b0;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
      is_branch     = 1'b0;
      is_jal        = 1'b0;
      is_jalr       = 1'b0;
      ctl_alu_src   = 1'b0;
      ctl_mem_read  = 1'b0;
      ctl_mem_write = 1'b0;
      ctl_reg_write = 1'b0;
      imm           = '0;
      alu_op        = ALU_ADD;
      case (opcode)
         OP_LUI: begin
            legal = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1; alu_op = ALU_PASSB;
            imm = {ifid_instr[31:12], 12'b0};
         end
         OP_AUIPC: begin
            legal = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1;
            imm = {ifid_instr[31:12], 12'b0};
         end
         OP_JAL: begin
            legal = 1'b1; is_jal = 1'b1; ctl_reg_write = 1'b1;
            imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12], ifid_instr[20], ifid_instr[30:21], 1'b0};
         end
         OP_JALR: begin
            legal = 1'b1; is_jalr = 1'b1; uses_rs1 = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1;
            imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
         end
         OP_BRANCH: begin
            legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            is_branch = legal; uses_rs1 = legal; uses_rs2 = legal; alu_op = ALU_SUB;
            imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7], ifid_instr[30:25], ifid_instr[11:8], 1'b0};
         end
         OP_LOAD: begin
            legal = 1'b1; uses_rs1 = 1'b1; ctl_alu_src = 1'b1; ctl_mem_read = 1'b1; ctl_reg_write = 1'b1;
            imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
         end
         OP_STORE: begin
            legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; ctl_alu_src = 1'b1; ctl_mem_write = 1'b1;
            imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
         end
         OP_IMM: begin
            legal = 1'b1; uses_rs1 = 1'b1; ctl_alu_src = 1'b1; ctl_reg_write = 1'b1;
            imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            alu_op = alu_op_decode(funct3, ifid_instr[30], 1'b0);
         end
         OP_REG: begin
            legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; ctl_reg_write = 1'b1;
            alu_op = alu_op_decode(funct3, ifid_instr[30], 1'b1);
         end
         default: legal = 1'b0;
      endcase
   end

   logic live;
   assign live = ifid_valid && legal;

   logic e_hit, m_hit, load_use, br_hazard, hazard;
   assign e_hit = (uses_rs1 && rs1_d != 5'd0 && rs1_d == rd_e) ||
                  (uses_rs2 && rs2_d != 5'd0 && rs2_d == rd_e);
   assign m_hit = (uses_rs1 && rs1_d != 5'd0 && rs1_d == rd_m) ||
                  (uses_rs2 && rs2_d != 5'd0 && rs2_d == rd_m);
   assign load_use  = mem_read_e && e_hit;
   assign br_hazard = (is_branch || is_jalr) && ((reg_write_e && e_hit) || (mem_read_m && m_hit));
   assign hazard    = live && (load_use || br_hazard);
   assign stall_f   = hazard && !flush_m && !rst;

   logic        fwd_ok;
   logic [31:0] cmp_a, cmp_b;
   logic        taken;
   assign fwd_ok = reg_write_m && !mem_read_m;
   assign cmp_a  = (fwd_ok && rs1_d != 5'd0 && rd_m == rs1_d) ? alu_result_m : rs1_data_d;
   assign cmp_b  = (fwd_ok && rs2_d != 5'd0 && rd_m == rs2_d) ? alu_result_m : rs2_data_d;

   // branch condition from funct3 on M-forwarded operands
   always_comb begin
      taken = 1'b0;
      if (is_jal || is_jalr) begin
         taken = 1'b1;
      end else if (is_branch) begin
         case (funct3)
            F3_BEQ:  taken = (cmp_a == cmp_b);
            F3_BNE:  taken = (cmp_a != cmp_b);
            F3_BLT:  taken = ($signed(cmp_a) <  $signed(cmp_b));
            F3_BGE:  taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: taken = (cmp_a <  cmp_b);
            F3_BGEU: taken = (cmp_a >= cmp_b);
            default: taken = 1'b0;
         endcase
      end
   end

   assign branch_next_addr_d = is_jalr ? ((cmp_a + imm) & ~32'h1) : (ifid_pc + imm);
   assign branch_d = live && taken && !stall_f && !flush_m && !rst;

   logic kill;
   assign kill = stall_f || flush_m;

   assign valid_d     = live && !kill;
   assign reg_write_d = live && !kill && ctl_reg_write && (rd_d != 5'd0);
   assign mem_read_d  = live && !kill && ctl_mem_read;
   assign mem_write_d = live && !kill && ctl_mem_write;
   assign alu_src_d   = live && ctl_alu_src;
   assign alu_op_d    = live ? alu_op : ALU_ADD;
   assign imm_d       = live ? imm : '0;
   assign funct3_d    = live ? funct3 : 3'd0;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for the decode stage
module tb_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_f, pc_f;
   logic        flush_m, reg_write_e, mem_read_e, reg_write_m, mem_read_m, reg_write_w;
   logic [4:0]  rd_e, rd_m, rd_w;
   logic [31:0] alu_result_m, rd_data_w;
   logic        stall_f, branch_d, valid_d, alu_src_d, mem_read_d, mem_write_d, reg_write_d;
   logic [31:0] branch_next_addr_d, pc_d, rs1_data_d, rs2_data_d, imm_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [2:0]  funct3_d;
   logic [3:0]  alu_op_d;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode dut (
      .clk(clk), .rst(rst), .instruction_f(instruction_f), .pc_f(pc_f), .flush_m(flush_m),
      .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .rd_e(rd_e),
      .reg_write_m(reg_write_m), .mem_read_m(mem_read_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .rd_data_w(rd_data_w),
      .stall_f(stall_f), .branch_d(branch_d), .branch_next_addr_d(branch_next_addr_d),
      .valid_d(valid_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .funct3_d(funct3_d),
      .alu_op_d(alu_op_d), .alu_src_d(alu_src_d), .mem_read_d(mem_read_d),
      .mem_write_d(mem_write_d), .reg_write_d(reg_write_d)
   );

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
      enc_r = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rd, input logic [6:0] op);
      enc_i = {imm[11:0], rs1, 3'b000, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      enc_s = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      enc_b = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic idle();
      flush_m = 0; reg_write_e = 0; mem_read_e = 0; rd_e = 0;
      reg_write_m = 0; mem_read_m = 0; rd_m = 0; alu_result_m = 0;
      reg_write_w = 0; rd_w = 0; rd_data_w = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] instr, input logic [31:0] pc);
      instruction_f = instr;
      pc_f = pc;
      step();
   endtask

   task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
      instruction_f = NOP; pc_f = 0;
      reg_write_w = 1; rd_w = idx; rd_data_w = val;
      step();
      reg_write_w = 0;
   endtask

   initial begin
      idle();
      rst = 1; instruction_f = NOP; pc_f = 0;
      step(); step();
      rst = 0;
      #1;
      check("rst_valid", valid_d, 0);
      check("rst_stall", stall_f, 0);
      check("rst_branch", branch_d, 0);
      check("rst_regwr", reg_write_d, 0);
      check("rst_alusrc", alu_src_d, 0);
      check("rst_imm", imm_d, 0);

      for (int i = 1; i < 32; i++) begin
         put(enc_r(5'(i), 5'(i), 5'd0), 32'h0);
         #1;
         check($sformatf("rst_x%0d", i), rs1_data_d, 0);
      end

      // write-back bypass then stored value
      put(enc_i(0, 5, 6, 7'h13), 32'h10);
      reg_write_w = 1; rd_w = 5; rd_data_w = 32'hDEAD_BEEF;
      #1;
      check("wbyp_rs1", rs1_data_d, 32'hDEAD_BEEF);
      check("wbyp_valid", valid_d, 1);
      check("wbyp_regwr", reg_write_d, 1);
      check("wbyp_alusrc", alu_src_d, 1);
      instruction_f = enc_i(1, 5, 7, 7'h13); pc_f = 32'h14;
      step();
      reg_write_w = 0;
      #1;
      check("wstore_rs1", rs1_data_d, 32'hDEAD_BEEF);
      check("wstore_imm", imm_d, 1);
      check("wstore_pc", pc_d, 32'h14);

      write_reg(1, 32'h55);
      write_reg(2, 32'h55);
      write_reg(8, 32'hFFFF_FFFF);
      write_reg(9, 32'h101);
      write_reg(0, 32'd123);
      put(enc_r(5'd0, 5'd0, 5'd0), 32'h18);
      #1;
      check("x0_read", rs1_data_d, 0);

      // load-use stall
      put(enc_r(1, 3, 4), 32'h20);
      mem_read_e = 1; reg_write_e = 1; rd_e = 3;
      #1;
      check("lu_stall", stall_f, 1);
      check("lu_valid", valid_d, 0);
      check("lu_memrd", mem_read_d, 0);
      instruction_f = enc_i(0, 0, 10, 7'h13); pc_f = 32'h24;
      step();
      idle(); mem_read_m = 1; reg_write_m = 1; rd_m = 3;
      #1;
      check("lu_rel_stall", stall_f, 0);
      check("lu_rel_valid", valid_d, 1);
      check("lu_rel_pc", pc_d, 32'h20);
      check("lu_rel_rd", rd_d, 4);
      idle();

      // taken BEQ and wrong-path squash
      put(enc_b(32'h20, 2, 1, 3'b000), 32'h40);
      #1;
      check("beq_branch", branch_d, 1);
      check("beq_target", branch_next_addr_d, 32'h60);
      check("beq_imm", imm_d, 32'h20);
      put(enc_r(1, 1, 11), 32'h44);
      #1;
      check("beq_squash", valid_d, 0);
      check("beq_squash_br", branch_d, 0);

      put(enc_b(32'h20, 2, 1, 3'b001), 32'h50);
      #1;
      check("bne_nt", branch_d, 0);
      check("bne_valid", valid_d, 1);
      put(enc_b(32'h10, 1, 8, 3'b110), 32'h60);
      #1;
      check("bltu_nt", branch_d, 0);
      put(enc_b(32'h10, 1, 8, 3'b100), 32'h64);
      #1;
      check("blt_t", branch_d, 1);
      check("blt_target", branch_next_addr_d, 32'h74);
      put(NOP, 32'h68);

      // JALR target masking
      put(enc_i(4, 9, 1, 7'b1100111), 32'h80);
      #1;
      check("jalr_branch", branch_d, 1);
      check("jalr_target", branch_next_addr_d, 32'h104);
      check("jalr_regwr", reg_write_d, 1);
      put(NOP, 32'h84);
      #1;
      check("jalr_squash", valid_d, 0);

      // BNE with rs1 forwarded from M
      put(enc_b(32'h10, 2, 1, 3'b001), 32'h90);
      reg_write_m = 1; rd_m = 1; alu_result_m = 32'h77;
      #1;
      check("fwd_stall", stall_f, 0);
      check("fwd_branch", branch_d, 1);
      check("fwd_target", branch_next_addr_d, 32'hA0);
      check("fwd_rs1_data", rs1_data_d, 32'h55);
      idle();
      put(NOP, 32'h94);

      // branch operand hazards from E then M load
      put(enc_b(32'h8, 2, 1, 3'b000), 32'hB0);
      reg_write_e = 1; rd_e = 2;
      #1;
      check("bhz_e_stall", stall_f, 1);
      check("bhz_e_branch", branch_d, 0);
      check("bhz_e_valid", valid_d, 0);
      step();
      idle(); mem_read_m = 1; reg_write_m = 1; rd_m = 2;
      #1;
      check("bhz_m_stall", stall_f, 1);
      step();
      idle();
      #1;
      check("bhz_rel_stall", stall_f, 0);
      check("bhz_rel_pc", pc_d, 32'hB0);
      check("bhz_rel_branch", branch_d, 1);
      check("bhz_rel_target", branch_next_addr_d, 32'hB8);
      put(NOP, 32'hB4);

      // flush overrides branch and hazard
      put(enc_b(32'h8, 2, 1, 3'b000), 32'hC0);
      reg_write_e = 1; rd_e = 1; flush_m = 1;
      #1;
      check("fl_branch", branch_d, 0);
      check("fl_stall", stall_f, 0);
      check("fl_valid", valid_d, 0);
      instruction_f = enc_r(1, 1, 12); pc_f = 32'hC4;
      step();
      idle();
      #1;
      check("fl_bubble_valid", valid_d, 0);
      check("fl_bubble_pc", pc_d, 0);
      check("fl_bubble_rd", rd_d, 0);

      // illegal opcode is a bubble with no stall
      put(32'hFFFF_FFFF, 32'hD0);
      mem_read_e = 1; rd_e = 31;
      #1;
      check("ill_stall", stall_f, 0);
      check("ill_valid", valid_d, 0);
      check("ill_regwr", reg_write_d, 0);
      idle();

      // JAL x0 backwards from pc 0 wraps
      put(enc_j(32'hFFFF_FFFC, 0), 32'h0);
      #1;
      check("jal_branch", branch_d, 1);
      check("jal_target", branch_next_addr_d, 32'hFFFF_FFFC);
      check("jal_imm", imm_d, 32'hFFFF_FFFC);
      check("jal_regwr_x0", reg_write_d, 0);
      put(NOP, 32'h4);

      put(enc_s(8, 2, 1), 32'hE0);
      #1;
      check("sw_imm", imm_d, 8);
      check("sw_memwr", mem_write_d, 1);
      check("sw_regwr", reg_write_d, 0);
      check("sw_rs2", rs2_data_d, 32'h55);
      put(enc_i(32'hFFF, 0, 1, 7'h13), 32'hE4);
      #1;
      check("addi_neg_imm", imm_d, 32'hFFFF_FFFF);

      // reset during a load-use stall
      put(enc_r(1, 3, 4), 32'hF0);
      mem_read_e = 1; rd_e = 3; rst = 1;
      #1;
      check("rs_stall", stall_f, 0);
      check("rs_branch", branch_d, 0);
      instruction_f = NOP;
      step();
      rst = 0; idle();
      #1;
      check("rs_valid", valid_d, 0);
      put(enc_i(0, 5, 7, 7'h13), 32'hF4);
      #1;
      check("rs_x5_cleared", rs1_data_d, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
